// File: rtl/step_chart_gen_pkg.sv
// Shared encodings for the step chart generator: phase codes, column
// indices and the per-level arrow density thresholds.
package step_chart_gen_pkg;

  // Phase encoding, also driven directly on the phase output.
  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_INTRO = 2'd1,
    PH_PLAY  = 2'd2,
    PH_REST  = 2'd3
  } phase_e;

  // Column index of each bit in the spawn pattern.
  localparam logic [1:0] COL_LEFT  = 2'd0;
  localparam logic [1:0] COL_UP    = 2'd1;
  localparam logic [1:0] COL_DOWN  = 2'd2;
  localparam logic [1:0] COL_RIGHT = 2'd3;

  // An arrow is attempted when lfsr[7:0] is below this threshold;
  // the entry is selected by the latched difficulty level.
  localparam logic [3:0][7:0] DENSITY_T = {8'd208, 8'd160, 8'd112, 8'd64};

endpackage

// File: rtl/step_chart_gen_lfsr10.sv
// 10-bit Fibonacci LFSR, x^10 + x^7 + 1, shifting left every clock.
module step_lfsr10 #(
  parameter logic [9:0] SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] state
);

  logic [9:0] state_q;
  logic [9:0] state_d;

  // Next state: shift left, feedback from taps 9 and 6.
  always_comb begin
    state_d = {state_q[8:0], state_q[9] ^ state_q[6]};
  end

  // Free-running register; a nonzero seed keeps it off the all-zero lockup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/step_chart_gen.sv
// Step chart generator: turns the beat tick and an LFSR into a playable
// per-beat arrow pattern with intro/rest phrasing, per-column cooldown and
// limited jumps.
module step_chart_gen
  import step_chart_gen_pkg::*;
#(
  parameter logic [9:0] SEED       = 10'h2A5,
  parameter int         INTRO_LEN  = 8,
  parameter int         PHRASE_LEN = 16,
  parameter int         REST_LEN   = 4,
  parameter int         MIN_GAP    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       beat,
  input  logic [1:0] level,
  output logic [3:0] spawn,
  output logic       spawned,
  output logic [1:0] phase
);

  localparam int CNT_W = 8;

  logic [9:0]       lfsr;
  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       level_q, level_d;
  logic [3:0][1:0]  cool_q, cool_d;
  logic [3:0]       spawn_q, spawn_d;
  logic             spawned_q, spawned_d;

  logic [3:0] free_col;
  logic [3:0] pattern;
  logic [1:0] probe;
  logic [1:0] prim;
  logic [1:0] second;
  logic       found;
  logic       prev_single;

  step_lfsr10 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr)
  );

  // Candidate pattern for this beat from the current LFSR value and cooldowns.
  always_comb begin
    pattern     = 4'b0000;
    found       = 1'b0;
    prim        = lfsr[1:0];
    probe       = lfsr[1:0];
    second      = 2'd0;
    prev_single = (spawn_q != 4'b0000) && ((spawn_q & (spawn_q - 4'd1)) == 4'b0000);
    for (int i = 0; i < 4; i++) begin
      free_col[i] = (cool_q[i] == 2'd0);
    end
    if (lfsr[7:0] < DENSITY_T[level_q]) begin
      // Probe from the highest offset down so the lowest free offset wins.
      for (int k = 3; k >= 0; k--) begin
        probe = lfsr[1:0] + 2'(k);
        if (free_col[probe]) begin
          prim  = probe;
          found = 1'b1;
        end
      end
      if (found) begin
        pattern[prim] = 1'b1;
        // Jumps only follow a single arrow, so two jump beats never touch.
        if (level_q >= 2'd2 && lfsr[9:8] == 2'b11 && prev_single) begin
          second = prim + 2'd1 + {1'b0, lfsr[2]};
          if (free_col[second]) pattern[second] = 1'b1;
        end
      end
    end
  end

  // Phase sequencing, level latch, cooldown bookkeeping and output pattern.
  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    cool_d    = cool_q;
    spawn_d   = spawn_q;
    spawned_d = 1'b0;
    if (!enable) begin
      // Dropping enable wins over a coincident beat.
      phase_d = PH_IDLE;
      cnt_d   = '0;
      spawn_d = 4'b0000;
      cool_d  = '0;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d = PH_INTRO;
          cnt_d   = '0;
          spawn_d = 4'b0000;
        end
        PH_INTRO: begin
          if (beat) begin
            spawn_d = 4'b0000;
            if (cnt_q == CNT_W'(INTRO_LEN - 1)) begin
              phase_d = PH_PLAY;
              cnt_d   = '0;
              level_d = level;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        PH_PLAY: begin
          if (beat) begin
            spawn_d   = pattern;
            spawned_d = (pattern != 4'b0000);
            for (int i = 0; i < 4; i++) begin
              if (pattern[i])              cool_d[i] = 2'(MIN_GAP);
              else if (cool_q[i] != 2'd0) cool_d[i] = cool_q[i] - 2'd1;
            end
            if (cnt_q == CNT_W'(PHRASE_LEN - 1)) begin
              phase_d = PH_REST;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          if (beat) begin
            spawn_d = 4'b0000;
            for (int i = 0; i < 4; i++) begin
              if (cool_q[i] != 2'd0) cool_d[i] = cool_q[i] - 2'd1;
            end
            if (cnt_q == CNT_W'(REST_LEN - 1)) begin
              phase_d = PH_PLAY;
              cnt_d   = '0;
              level_d = level;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      cnt_q     <= '0;
      level_q   <= 2'd0;
      cool_q    <= '0;
      spawn_q   <= 4'b0000;
      spawned_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      cool_q    <= cool_d;
      spawn_q   <= spawn_d;
      spawned_q <= spawned_d;
    end
  end

  assign spawn   = spawn_q;
  assign spawned = spawned_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_step_chart_gen.sv
// Directed and table-driven bench for step_chart_gen with a behavioural
// reference of the chart rules.
module tb_step_chart_gen;
  import step_chart_gen_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       beat = 1'b0;
  logic [1:0] level = 2'd0;
  logic [3:0] spawn;
  logic       spawned;
  logic [1:0] phase;

  always #5 clk = ~clk;

  step_chart_gen dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .beat    (beat),
    .level   (level),
    .spawn   (spawn),
    .spawned (spawned),
    .phase   (phase)
  );

  int total = 0;
  int bad = 0;

  // Reference LFSR stepped alongside the design.
  logic [9:0] m_lfsr;
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 10'h2A5;
    else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  int         m_phase = 0;
  int         m_cnt = 0;
  int         m_level = 0;
  int         m_cool[4] = '{0, 0, 0, 0};
  logic [3:0] m_spawn = 4'b0;

  int gidx = 0;
  int last_sp[4] = '{-100, -100, -100, -100};
  int play_beats, nz_beats, jump_beats, multi_beats, over2_beats, consec_jumps, cool_viol;
  bit prev_jump;

  typedef struct {
    logic [1:0] lvl_in;
    logic [1:0] exp_phase;
    logic       exp_quiet;
    logic [1:0] exp_lvl;
  } vec_t;
  vec_t tbl[28];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    play_beats = 0; nz_beats = 0; jump_beats = 0; multi_beats = 0;
    over2_beats = 0; consec_jumps = 0; cool_viol = 0; prev_jump = 0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_spawn = 4'b0;
    for (int c = 0; c < 4; c++) begin
      m_cool[c]  = 0;
      last_sp[c] = -100;
    end
    prev_jump = 0;
  endtask

  function automatic logic [3:0] gen(input logic [9:0] L);
    logic [3:0] p;
    int thr, c, d;
    p   = 4'b0;
    thr = 64 + 48 * m_level;
    c   = -1;
    if (int'(L[7:0]) < thr) begin
      for (int k = 0; k < 4; k++)
        if (c < 0 && m_cool[(int'(L[1:0]) + k) % 4] == 0) c = (int'(L[1:0]) + k) % 4;
      if (c >= 0) begin
        p[c] = 1'b1;
        if (m_level >= 2 && L[9:8] == 2'b11 && $countones(m_spawn) == 1) begin
          d = (c + 1 + int'(L[2])) % 4;
          if (m_cool[d] == 0) p[d] = 1'b1;
        end
      end
    end
    return p;
  endfunction

  task automatic model_beat(input logic [9:0] L);
    logic [3:0] p;
    case (m_phase)
      1: begin
        m_spawn = 4'b0;
        if (m_cnt == 7) begin m_phase = 2; m_cnt = 0; m_level = int'(level); end
        else m_cnt++;
      end
      2: begin
        p = gen(L);
        for (int c = 0; c < 4; c++)
          m_cool[c] = p[c] ? 2 : (m_cool[c] > 0 ? m_cool[c] - 1 : 0);
        m_spawn = p;
        m_cnt++;
        if (m_cnt == 16) begin m_phase = 3; m_cnt = 0; end
      end
      3: begin
        m_spawn = 4'b0;
        for (int c = 0; c < 4; c++) if (m_cool[c] > 0) m_cool[c]--;
        m_cnt++;
        if (m_cnt == 4) begin m_phase = 2; m_cnt = 0; m_level = int'(level); end
      end
      default: m_spawn = 4'b0;
    endcase
  endtask

  // One beat pulse; model advances on the same edge, outputs checked after it.
  task automatic do_beat();
    logic [9:0] L;
    int pre;
    int n;
    @(negedge clk);
    beat = 1'b1;
    L    = m_lfsr;
    pre  = m_phase;
    model_beat(L);
    @(posedge clk);
    #1;
    beat = 1'b0;
    check("spawn", 32'(spawn), 32'(m_spawn));
    check("spawned", 32'(spawned), 32'(m_spawn != 4'b0));
    check("phase", 32'(phase), 32'(m_phase));
    gidx++;
    n = $countones(spawn);
    for (int c = 0; c < 4; c++) begin
      if (spawn[c]) begin
        if (gidx - last_sp[c] < 3) cool_viol++;
        last_sp[c] = gidx;
      end
    end
    if (n > 1) multi_beats++;
    if (n > 2) over2_beats++;
    if (n == 2 && prev_jump) consec_jumps++;
    prev_jump = (n == 2);
    if (pre == 2) begin
      play_beats++;
      if (n != 0) nz_beats++;
      if (n == 2) jump_beats++;
    end
    @(posedge clk);
    #1;
    check("spawned_pulse", 32'(spawned), 32'd0);
  endtask

  task automatic start_enable();
    enable = 1'b1;
    @(posedge clk);
    #1;
    m_phase = 1;
    m_cnt   = 0;
    check("enter_intro", 32'(phase), 32'(PH_INTRO));
  endtask

  task automatic run_play(input int want);
    int guard;
    guard = 0;
    clear_stats();
    while (play_beats < want && guard < 3000) begin
      do_beat();
      guard++;
    end
    check("play_budget", 32'(play_beats >= want), 32'd1);
  endtask

  initial begin
    int   guard;
    logic [3:0] target;

    // Intro, one phrase and one rest; level bumped to 3 on the 5th play beat.
    for (int i = 0; i < 8; i++)
      tbl[i] = '{2'd0, (i == 7) ? 2'd2 : 2'd1, 1'b1, 2'd0};
    for (int p = 1; p <= 16; p++)
      tbl[7 + p] = '{(p >= 5) ? 2'd3 : 2'd0, (p == 16) ? 2'd3 : 2'd2, 1'b0, 2'd0};
    for (int r = 1; r <= 4; r++)
      tbl[23 + r] = '{2'd3, (r == 4) ? 2'd2 : 2'd3, 1'b1, (r == 4) ? 2'd3 : 2'd0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_spawn", 32'(spawn), 32'd0);
    check("rst_spawned", 32'(spawned), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_lfsr", 32'(dut.lfsr), 32'h2A5);

    // Intro, phrase, rest and mid-phrase level change.
    start_enable();
    for (int i = 0; i < 28; i++) begin
      level = tbl[i].lvl_in;
      do_beat();
      check($sformatf("tbl_phase[%0d]", i), 32'(phase), 32'(tbl[i].exp_phase));
      check($sformatf("tbl_level[%0d]", i), 32'(dut.level_q), 32'(tbl[i].exp_lvl));
      if (tbl[i].exp_quiet) check($sformatf("tbl_quiet[%0d]", i), 32'(spawn), 32'd0);
    end

    // Asynchronous reset while a DOWN arrow is displayed.
    target = 4'b0001 << COL_DOWN;
    guard  = 0;
    while (!(spawn == target && phase == 2'd2) && guard < 400) begin
      do_beat();
      guard++;
    end
    check("find_down", 32'(spawn), 32'(target));
    @(posedge clk);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("midrst_spawn", 32'(spawn), 32'd0);
    check("midrst_phase", 32'(phase), 32'd0);
    check("midrst_spawned", 32'(spawned), 32'd0);
    model_reset();
    m_level = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_lfsr", 32'(dut.lfsr), 32'h2A5);

    // Level 0 long run: single arrows, about one beat in four.
    level = 2'd0;
    start_enable();
    run_play(2000);
    check("l0_multi", 32'(multi_beats), 32'd0);
    check("l0_density_lo", 32'(nz_beats * 100 >= 22 * play_beats), 32'd1);
    check("l0_density_hi", 32'(nz_beats * 100 <= 28 * play_beats), 32'd1);
    check("l0_cooldown", 32'(cool_viol), 32'd0);

    // Enable drops on the same edge as a beat.
    @(negedge clk);
    beat   = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    beat = 1'b0;
    check("drop_phase", 32'(phase), 32'd0);
    check("drop_spawn", 32'(spawn), 32'd0);
    check("drop_spawned", 32'(spawned), 32'd0);
    model_reset();
    level = 2'd3;
    start_enable();
    check("reen_cool", 32'(dut.cool_q), 32'd0);
    for (int i = 0; i < 8; i++) begin
      do_beat();
      check($sformatf("reen_intro[%0d]", i), 32'(phase), (i == 7) ? 32'd2 : 32'd1);
    end

    // Level 3 long run: jumps present, never stacked, cooldowns honoured.
    run_play(2000);
    check("l3_jumps", 32'(jump_beats > 0), 32'd1);
    check("l3_over2", 32'(over2_beats), 32'd0);
    check("l3_consec", 32'(consec_jumps), 32'd0);
    check("l3_cooldown", 32'(cool_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/step_chart_gen.md
Name: step_chart_gen

Overview:
- Generates the per-beat arrow pattern that enters row 0 of the four falling-note columns (left, up, down, right).
- Replaces raw LFSR bits with a playable chart: density set by difficulty level, per-column cooldown, jump (double-arrow) limits, intro and rest phrases.
- Sits between the beat-rate tick and the column shift registers.
- The column shifters sample spawn on the beat after it is issued, so spawn is held stable for a full beat.

Parameters:
- SEED, 10'h2A5, LFSR reset value; must be nonzero.
- INTRO_LEN, 8, empty beats after enable before the first arrow.
- PHRASE_LEN, 16, play beats per phrase.
- REST_LEN, 4, empty beats after each phrase.
- MIN_GAP, 2, beats a column stays blocked after it spawns (1..3).

Ports:
- clk  in  1  system clock (divided clock tap).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; low forces IDLE.
- beat  in  1  one-cycle pulse, once per row shift.
- level  in  2  difficulty 0..3; latched only at phrase start.
- spawn  out  4  arrow pattern; bit0 left, bit1 up, bit2 down, bit3 right. Held between beats.
- spawned  out  1  one-cycle pulse when a nonzero pattern is issued.
- phase  out  2  0 IDLE, 1 INTRO, 2 PLAY, 3 REST.

Behaviour:
- Reset (async, active-high):
  - spawn=0, spawned=0, phase=IDLE.
  - lfsr=SEED, beat_cnt=0, all cooldowns=0, level_q=0.
- LFSR:
  - 10-bit Fibonacci, polynomial x^10+x^7+1, shifting left with new bit = lfsr[9]^lfsr[6].
  - Advances every clk cycle regardless of state; never reaches 0.
- All state and outputs update on the clk edge where beat=1 (one-cycle latency).
- spawned is high only in that cycle. spawn holds until the next beat.
- FSM:
  - IDLE: spawn=0. When enable=1, go to INTRO with beat_cnt=0.
  - INTRO: each beat emits 0 and increments beat_cnt. On the INTRO_LEN-th beat, go to PLAY, beat_cnt=0, level_q=level.
  - PLAY: each beat emits a generated pattern (below). On the PHRASE_LEN-th beat, go to REST, beat_cnt=0.
  - REST: emits 0. On the REST_LEN-th beat, go to PLAY, beat_cnt=0, level_q=level.
  - Any state: enable=0 forces IDLE next clk and clears spawn and cooldowns. This holds even when enable drops in the same cycle as beat. lfsr keeps running.
- Pattern generation in PLAY, using lfsr value L sampled at the beat edge:
  - Density threshold T by level_q: 0→64, 1→112, 2→160, 3→208.
  - If L[7:0] >= T, emit 0.
  - Otherwise the primary column is c=L[1:0]. If c is cooling, probe c+1, c+2, c+3 (mod 4) and take the first free one. If none is free, emit 0.
  - Jump: only when level_q>=2, L[9:8]==2'b11 and the previous beat emitted a single arrow. The second column is d=c+1+L[2] (mod 4), using the resolved c.
  - If d is cooling, drop to a single arrow; no probing for d.
  - Never more than 2 bits set. Never two consecutive jump beats.
- Cooldown:
  - Each column has a 2-bit counter. On a beat where the column spawns, load MIN_GAP.
  - On other beats in PLAY or REST, decrement when nonzero.
  - A column is free only when its counter is 0.
  - With MIN_GAP=2, a column that spawns at beat n cannot spawn at n+1 or n+2.
- A level change mid-phrase has no effect until the next PLAY entry.
- Reset asserted mid-operation returns everything to the reset values immediately.

Decomposition:
- Shared package holds:
  - phase encoding constants.
  - column index constants (LEFT=0, UP=1, DOWN=2, RIGHT=3).
  - the 4-entry density threshold table.
- Sub-module: step_lfsr10 (clk, reset, seed parameter, 10-bit state out).
- FSM, cooldowns and column selection stay in the top body.

Test Plan:
1. Reset mid-PLAY with spawn=4'b0100 → spawn=0, phase=0, spawned=0 the same cycle. After release, lfsr equals 10'h2A5.
2. enable=1, then 8 beats → phase=1 throughout and spawn=0 on every beat. After the 8th beat phase=2. The first PLAY beat can spawn.
3. level=0, 2000 PLAY beats → never more than 1 bit set. Nonzero-beat fraction is 25%±3%. No column spawns within 2 beats of itself.
4. level=3, 2000 beats → jumps occur, each with 2 distinct bits. No two consecutive jump beats. Cooldown rule holds across jumps.
5. Count 16 PLAY beats → phase=3 with 4 zero beats, then back to 2. A level change from 0 to 3 on PLAY beat 5 takes effect only after REST.
6. enable deasserted in the same cycle as beat → next cycle phase=0 and spawn=0. Re-enable → cooldowns are 0 and INTRO restarts with its full 8 beats.
